// File: rtl/kbd_threshold_entry.sv
// Keyboard-driven editor for the heart-monitor alarm thresholds (high/low BPM).
// Synchronizes the ASCII strobe, then runs an IDLE/ENTRY command FSM over a 3-digit BCD buffer.
module kbd_threshold_entry #(
    parameter int MAX_DIGITS   = 3,
    parameter int MIN_VAL      = 30,
    parameter int MAX_VAL      = 220,
    parameter int DEFAULT_HIGH = 120,
    parameter int DEFAULT_LOW  = 50
) (
    input  logic         CLK100MHZ,
    input  logic         reset,
    input  logic [127:0] key_pressed,
    input  logic         ascii_code_done,
    output logic [7:0]   thr_high,
    output logic [7:0]   thr_low,
    output logic         entry_active,
    output logic         entry_field,
    output logic [9:0]   entry_value,
    output logic [1:0]   entry_count,
    output logic         commit_pulse,
    output logic         error_pulse
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);
    localparam logic [9:0] MIN_V   = 10'(MIN_VAL);
    localparam logic [9:0] MAX_V   = 10'(MAX_VAL);
    localparam logic [7:0] DEF_HI  = 8'(DEFAULT_HIGH);
    localparam logic [7:0] DEF_LO  = 8'(DEFAULT_LOW);

    typedef enum logic {S_IDLE, S_ENTRY} state_t;

    state_t      state, state_n;
    logic        s1, s2, s3, act, strobe;
    logic [7:0]  ch;
    logic [3:0]  d2, d1, d0, d2_n, d1_n, d0_n;
    logic [1:0]  count_n;
    logic        field_n, commit_n, error_n;
    logic [7:0]  thr_high_n, thr_low_n;
    logic [9:0]  value_n;
    logic        is_digit, is_h, is_l, in_range, order_ok;
    logic        unused_key_bits;

    assign unused_key_bits = ^key_pressed[127:8];

    function automatic logic [9:0] bcd_value(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] c);
        return 10'(a) * 10'd100 + 10'(b) * 10'd10 + 10'(c);
    endfunction

    assign strobe       = s2 & ~s3;
    assign entry_active = (state == S_ENTRY);

    assign is_digit = (ch >= 8'h30) && (ch <= 8'h39);
    assign is_h     = (ch == 8'h48) || (ch == 8'h68);
    assign is_l     = (ch == 8'h4C) || (ch == 8'h6C);
    // Full 10-bit compare so that e.g. 300 is rejected rather than wrapping to 44.
    assign in_range = (entry_value >= MIN_V) && (entry_value <= MAX_V);
    assign order_ok = entry_field ? (entry_value > {2'b00, thr_low})
                                  : (entry_value < {2'b00, thr_high});

    always_ff @(posedge CLK100MHZ) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            act          <= 1'b0;
            ch           <= 8'h00;
            d2           <= 4'd0;
            d1           <= 4'd0;
            d0           <= 4'd0;
            entry_count  <= 2'd0;
            entry_value  <= 10'd0;
            entry_field  <= 1'b0;
            thr_high     <= DEF_HI;
            thr_low      <= DEF_LO;
            commit_pulse <= 1'b0;
            error_pulse  <= 1'b0;
        end else begin
            s1           <= ascii_code_done;
            s2           <= s1;
            s3           <= s2;
            act          <= strobe;
            if (strobe) ch <= key_pressed[7:0];
            d2           <= d2_n;
            d1           <= d1_n;
            d0           <= d0_n;
            entry_count  <= count_n;
            entry_value  <= value_n;
            entry_field  <= field_n;
            thr_high     <= thr_high_n;
            thr_low      <= thr_low_n;
            commit_pulse <= commit_n;
            error_pulse  <= error_n;
        end
    end

    always_comb begin
        state_n    = state;
        field_n    = entry_field;
        d2_n       = d2;
        d1_n       = d1;
        d0_n       = d0;
        count_n    = entry_count;
        thr_high_n = thr_high;
        thr_low_n  = thr_low;
        commit_n   = 1'b0;
        error_n    = 1'b0;

        if (act) begin
            unique case (state)
                S_IDLE: begin
                    if (is_h || is_l) begin
                        field_n = is_h;
                        d2_n    = 4'd0;
                        d1_n    = 4'd0;
                        d0_n    = 4'd0;
                        count_n = 2'd0;
                        state_n = S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (is_digit) begin
                        if (entry_count < MAX_CNT) begin
                            d2_n    = d1;
                            d1_n    = d0;
                            d0_n    = ch[3:0];
                            count_n = entry_count + 2'd1;
                        end else begin
                            error_n = 1'b1;
                        end
                    end else if (ch == 8'h08) begin
                        if (entry_count != 2'd0) begin
                            d0_n    = d1;
                            d1_n    = d2;
                            d2_n    = 4'd0;
                            count_n = entry_count - 2'd1;
                        end
                    end else if (ch == 8'h1B) begin
                        d2_n    = 4'd0;
                        d1_n    = 4'd0;
                        d0_n    = 4'd0;
                        count_n = 2'd0;
                        state_n = S_IDLE;
                    end else if (is_h || is_l) begin
                        field_n = is_h;
                        d2_n    = 4'd0;
                        d1_n    = 4'd0;
                        d0_n    = 4'd0;
                        count_n = 2'd0;
                    end else if (ch == 8'h0D) begin
                        if (entry_count == 2'd0) begin
                            state_n = S_IDLE;
                        end else if (in_range && order_ok) begin
                            if (entry_field) thr_high_n = entry_value[7:0];
                            else             thr_low_n  = entry_value[7:0];
                            commit_n = 1'b1;
                            d2_n     = 4'd0;
                            d1_n     = 4'd0;
                            d0_n     = 4'd0;
                            count_n  = 2'd0;
                            state_n  = S_IDLE;
                        end else begin
                            error_n = 1'b1;
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        value_n = bcd_value(d2_n, d1_n, d0_n);
    end

endmodule

// File: tb/tb_kbd_threshold_entry.sv
// Scoreboard bench for kbd_threshold_entry: keystroke stimulus queues expected pulse events,
// a negedge monitor pops and checks them whenever commit_pulse or error_pulse fires.
module tb_kbd_threshold_entry;

    logic         clk;
    logic         reset;
    logic [127:0] key_pressed;
    logic         ascii_code_done;
    logic [7:0]   thr_high, thr_low;
    logic         entry_active, entry_field;
    logic [9:0]   entry_value;
    logic [1:0]   entry_count;
    logic         commit_pulse, error_pulse;

    typedef struct {
        bit is_commit;
        int high;
        int low;
        int active;
        int count;
    } event_t;

    event_t exp_q[$];
    int     check_count = 0;
    int     pass_count  = 0;

    localparam logic [7:0] K_ENTER = 8'h0D;
    localparam logic [7:0] K_ESC   = 8'h1B;
    localparam logic [7:0] K_BS    = 8'h08;

    kbd_threshold_entry dut (
        .CLK100MHZ      (clk),
        .reset          (reset),
        .key_pressed    (key_pressed),
        .ascii_code_done(ascii_code_done),
        .thr_high       (thr_high),
        .thr_low        (thr_low),
        .entry_active   (entry_active),
        .entry_field    (entry_field),
        .entry_value    (entry_value),
        .entry_count    (entry_count),
        .commit_pulse   (commit_pulse),
        .error_pulse    (error_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) pass_count++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic expect_event(input bit is_commit, input int high, input int low,
                                input int active, input int count);
        event_t e;
        e.is_commit = is_commit;
        e.high      = high;
        e.low       = low;
        e.active    = active;
        e.count     = count;
        exp_q.push_back(e);
    endtask

    // Press one key: strobe held for hold_cycles, then released long enough for the action to land.
    task automatic applyStimulus(input logic [7:0] key, input int hold_cycles = 4);
        @(negedge clk);
        key_pressed     = {key_pressed[119:0], key};
        ascii_code_done = 1'b1;
        repeat (hold_cycles) @(negedge clk);
        ascii_code_done = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (commit_pulse || error_pulse) begin
            event_t e;
            checkOutput("pulse_exclusive", int'(commit_pulse & error_pulse), 0);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pulse_is_commit", int'(commit_pulse), int'(e.is_commit));
                checkOutput("ev_thr_high", int'(thr_high), e.high);
                checkOutput("ev_thr_low", int'(thr_low), e.low);
                checkOutput("ev_entry_active", int'(entry_active), e.active);
                if (e.count >= 0) checkOutput("ev_entry_count", int'(entry_count), e.count);
            end
        end
    end

    initial begin
        int lat;
        reset           = 1'b0;
        key_pressed     = '0;
        ascii_code_done = 1'b0;

        // Reset held low with 'H' already asserted; release must yield exactly one action.
        @(negedge clk);
        key_pressed[7:0] = "H";
        ascii_code_done  = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("rst_thr_high", int'(thr_high), 120);
        checkOutput("rst_thr_low", int'(thr_low), 50);
        checkOutput("rst_entry_active", int'(entry_active), 0);
        checkOutput("rst_entry_count", int'(entry_count), 0);
        checkOutput("rst_entry_value", int'(entry_value), 0);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        ascii_code_done = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rel_entry_active", int'(entry_active), 1);
        checkOutput("rel_entry_field", int'(entry_field), 1);
        checkOutput("rel_entry_count", int'(entry_count), 0);
        applyStimulus("5", 100);
        checkOutput("held_digit_count", int'(entry_count), 1);
        checkOutput("held_digit_value", int'(entry_value), 5);
        applyStimulus(K_ESC);
        checkOutput("esc_idle", int'(entry_active), 0);

        // High threshold 150 with latency measured on the Enter key.
        applyStimulus("H");
        applyStimulus("1");
        applyStimulus("5");
        applyStimulus("0");
        checkOutput("h150_value", int'(entry_value), 150);
        checkOutput("h150_count", int'(entry_count), 3);
        expect_event(1'b1, 150, 50, 0, -1);
        lat = 0;
        @(negedge clk);
        key_pressed     = {key_pressed[119:0], K_ENTER};
        ascii_code_done = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (commit_pulse && lat == 0) lat = i;
        end
        ascii_code_done = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("commit_latency_edges", lat, 4);

        // Low threshold with backspace editing.
        applyStimulus("l");
        applyStimulus("4");
        applyStimulus("5");
        checkOutput("l45_value", int'(entry_value), 45);
        applyStimulus(K_BS);
        checkOutput("bs_value", int'(entry_value), 4);
        checkOutput("bs_count", int'(entry_count), 1);
        applyStimulus("0");
        checkOutput("l40_value", int'(entry_value), 40);
        expect_event(1'b1, 150, 40, 0, -1);
        applyStimulus(K_ENTER);

        // Out-of-range 300 rejected, then overflow digit.
        applyStimulus("H");
        applyStimulus("3");
        applyStimulus("0");
        applyStimulus("0");
        checkOutput("h300_value", int'(entry_value), 300);
        expect_event(1'b0, 150, 40, 1, 3);
        applyStimulus(K_ENTER);
        expect_event(1'b0, 150, 40, 1, 3);
        applyStimulus("5");
        checkOutput("overflow_value", int'(entry_value), 300);
        applyStimulus(K_ESC);

        // Bring high back to 120, then low 130 must be rejected (not below high).
        applyStimulus("H");
        applyStimulus("1");
        applyStimulus("2");
        applyStimulus("0");
        expect_event(1'b1, 120, 40, 0, -1);
        applyStimulus(K_ENTER);
        applyStimulus("L");
        applyStimulus("1");
        applyStimulus("3");
        applyStimulus("0");
        expect_event(1'b0, 120, 40, 1, 3);
        applyStimulus(K_ENTER);
        applyStimulus(K_ESC);
        checkOutput("l130_esc_idle", int'(entry_active), 0);
        checkOutput("l130_thr_low", int'(thr_low), 40);

        // Range boundaries: 30 and 220 accepted, 29 and 221 rejected.
        applyStimulus("L");
        applyStimulus("2");
        applyStimulus("9");
        expect_event(1'b0, 120, 40, 1, 2);
        applyStimulus(K_ENTER);
        applyStimulus("L");
        applyStimulus("3");
        applyStimulus("0");
        checkOutput("restart_field", int'(entry_field), 0);
        expect_event(1'b1, 120, 30, 0, -1);
        applyStimulus(K_ENTER);
        applyStimulus("h");
        applyStimulus("2");
        applyStimulus("2");
        applyStimulus("1");
        expect_event(1'b0, 120, 30, 1, 3);
        applyStimulus(K_ENTER);
        applyStimulus(K_BS);
        applyStimulus("0");
        checkOutput("h220_value", int'(entry_value), 220);
        expect_event(1'b1, 220, 30, 0, -1);
        applyStimulus(K_ENTER);

        // Enter with no digits just leaves, silently.
        applyStimulus("H");
        applyStimulus(K_ENTER);
        checkOutput("empty_enter_idle", int'(entry_active), 0);
        checkOutput("empty_enter_thr_high", int'(thr_high), 220);

        // Reset mid-entry discards digits and restores defaults; later Enter is ignored.
        applyStimulus("H");
        applyStimulus("9");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        applyStimulus(K_ENTER);
        checkOutput("post_rst_active", int'(entry_active), 0);
        checkOutput("post_rst_count", int'(entry_count), 0);
        checkOutput("post_rst_thr_high", int'(thr_high), 120);
        checkOutput("post_rst_thr_low", int'(thr_low), 50);

        repeat (20) @(negedge clk);
        checkOutput("pending_events", exp_q.size(), 0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/kbd_threshold_entry.md
Name: kbd_threshold_entry

Overview:
- Consumes the ASCII stream from the keyboard front end (`key_pressed` byte buffer plus `ascii_code_done` strobe).
- Interprets keystrokes as a small command/number editor that sets the heart-monitor alarm thresholds: high BPM and low BPM.
- Its outputs feed the alarm comparator and the VGA status overlay.

Parameters:
- MAX_DIGITS, 3, maximum decimal digits per entry (1..3).
- MIN_VAL, 30, smallest accepted threshold (BPM).
- MAX_VAL, 220, largest accepted threshold (BPM, ≤255).
- DEFAULT_HIGH, 120, thr_high value after reset.
- DEFAULT_LOW, 50, thr_low value after reset.

Ports:
- CLK100MHZ  input  1  system clock.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising CLK100MHZ).
- key_pressed  input  128  ASCII buffer; byte [7:0] is the most recent character.
- ascii_code_done  input  1  new-character indication; level/pulse from another timing domain, ≥2 clocks wide.
- thr_high  output  8  committed high threshold.
- thr_low  output  8  committed low threshold.
- entry_active  output  1  1 while in ENTRY state.
- entry_field  output  1  field being edited: 1 = high, 0 = low.
- entry_value  output  10  decimal value of digits typed so far (0..999).
- entry_count  output  2  number of digits held.
- commit_pulse  output  1  one-clock pulse when a threshold is updated.
- error_pulse  output  1  one-clock pulse on rejected Enter or digit overflow.

Behaviour:
- Reset (reset=0 at a rising edge):
  - thr_high=DEFAULT_HIGH, thr_low=DEFAULT_LOW.
  - state=IDLE, digits cleared, entry_count=0, entry_value=0, entry_field=0.
  - entry_active=0, pulses=0, synchronizer flops=0.
  - Reset mid-entry discards the entry; thresholds revert to defaults.
- Input sync:
  - ascii_code_done passes through 2 flops (s1, s2) plus s3 = previous s2.
  - strobe = s2 & ~s3.
  - ch = key_pressed[7:0], registered on the clock where strobe=1.
  - Action is applied on the following edge. A high first sampled at edge k produces output changes at edge k+3.
  - One action per rising edge of ascii_code_done; a level held high gives exactly one action.
- Digit storage:
  - Three 4-bit BCD registers d2 d1 d0, shifted left on digit entry: d2←d1, d1←d0, d0←new.
  - Backspace shifts right: d0←d1, d1←d2, d2←0.
  - entry_value = d2*100 + d1*10 + d0, registered.
- State IDLE:
  - 'H'/'h' (0x48/0x68): entry_field=1, clear digits, go ENTRY.
  - 'L'/'l' (0x4C/0x6C): entry_field=0, clear digits, go ENTRY.
  - All other codes are ignored, with no pulses.
- State ENTRY:
  - '0'..'9' (0x30..0x39):
    - If entry_count<MAX_DIGITS: shift in, count+1.
    - Else: digit ignored, error_pulse.
  - Backspace 0x08: if count>0, shift right, count-1. At count=0, no effect.
  - Esc 0x1B: discard, go IDLE, no pulse.
  - 'H'/'L' (either case): restart entry on the selected field; digits cleared.
  - Enter 0x0D:
    - count=0: go IDLE, no pulse.
    - Value accepted only if MIN_VAL ≤ value ≤ MAX_VAL, and value > thr_low (high field) or value < thr_high (low field).
    - Accepted: write the selected threshold, commit_pulse, go IDLE.
    - Rejected: thresholds unchanged, error_pulse, stay in ENTRY with digits kept so the user can backspace.
  - Other codes: ignored.
- Pulses are exactly one clock wide and never both high in the same clock.
- Comparisons use the full 10-bit entry_value; no truncation before range check (e.g., 300 is rejected, not wrapped to 44).

Test Plan:
- Reset held low 5 clocks → thr_high=120, thr_low=50, entry_active=0, entry_count=0; release with ascii_code_done high for 1 µs → single action only.
- Keys 'H','1','5','0',Enter → entry_value=150 before Enter; thr_high=150, one commit_pulse, entry_active=0; the commit lands 3 edges after ascii_code_done is first sampled high.
- Keys 'l','4','5',Backspace,'0',Enter → entry_value 45→4→40; thr_low=40, commit_pulse.
- Keys 'H','3','0','0',Enter → error_pulse, thr_high unchanged, entry_active=1; then '5' → error_pulse (overflow), entry_count=3.
- With thr_high=120, keys 'L','1','3','0',Enter → rejected (≥thr_high), error_pulse; Esc → IDLE, thr_low unchanged.
- Keys 'H','9', reset pulse, then Enter → after reset state IDLE, Enter ignored, thr_high=120, no pulses.
